// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory stage: access size codes and
// the controller FSM state encoding.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the datapath and the data-memory stage.
// Handshake: a request is taken on a rising edge where req_valid && ready;
// resp_valid is a one-cycle pulse, with rdata/fault qualified by it.
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        fault;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, addr, wdata,
    input  ready, resp_valid, rdata, fault
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, addr, wdata,
    output ready, resp_valid, rdata, fault
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: merges store data into the old word,
// extracts and extends load data, and flags misaligned/reserved requests.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] store_word,
  output logic [31:0] load_word,
  output logic        misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = old_word[{lane, 3'b000} +: 8];
  assign half_v = old_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    store_word = old_word;
    load_word  = '0;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        store_word[{lane, 3'b000} +: 8] = wdata[7:0];
        load_word = {{24{~uns & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        load_word  = {{16{~uns & half_v[15]}}, half_v};
        misaligned = lane[0];
      end
      SZ_WORD: begin
        store_word = wdata;
        load_word  = old_word;
        misaligned = (lane != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory stage: accepts one load/store at a time, waits LATENCY cycles,
// then performs the access and returns a registered one-cycle response.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_ctrl_if.slave  bus,
  output state_t          state
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state_d;
  logic [3:0]  cnt, cnt_d;
  logic        accept, done, commit;

  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [IW+1:0] addr_q;
  logic [31:0] wdata_q;

  logic        resp_q, fault_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH_WORDS];
  logic [IW-1:0] idx;
  logic [31:0] store_word, load_word;
  logic        misaligned;

  // Upper address bits alias onto the array and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^bus.addr[31:IW+2];

  assign accept = bus.req_valid && (state == ST_IDLE);
  assign done   = (state == ST_DONE);
  assign idx    = addr_q[IW+1:2];
  assign commit = done && we_q && !misaligned && !reset;

  mem_lane_align u_align (
    .size       (size_q),
    .uns        (uns_q),
    .lane       (addr_q[1:0]),
    .old_word   (mem[idx]),
    .wdata      (wdata_q),
    .store_word (store_word),
    .load_word  (load_word),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cnt_d   = 4'd0;
          state_d = (LATENCY > 0) ? ST_WAIT : ST_DONE;
        end
      end
      ST_WAIT: begin
        if (cnt == LAST) state_d = ST_DONE;
        else             cnt_d   = cnt + 4'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      resp_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      resp_q  <= done;
      fault_q <= done && misaligned;
      rdata_q <= (done && !we_q && !misaligned) ? load_word : '0;
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        size_q  <= bus.req_size;
        addr_q  <= bus.addr[IW+1:0];
        wdata_q <= bus.wdata;
      end
    end
  end

  // Array has no reset; the write lands on the edge that leaves DONE.
  always_ff @(posedge clk) begin
    if (commit) mem[idx] <= store_word;
  end

  assign bus.ready      = (state == ST_IDLE);
  assign bus.resp_valid = resp_q;
  assign bus.rdata      = rdata_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with LATENCY=2 and one with
// LATENCY=0, sharing stimulus; sel picks which instance is active.
module tb_data_mem_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  int          total = 0;
  int          bad = 0;
  state_t      state_a, state_b;

  always #5 clk = ~clk;

  data_mem_ctrl_if ifa ();
  data_mem_ctrl_if ifb ();

  assign ifa.req_valid    = req_valid & ~sel;
  assign ifb.req_valid    = req_valid & sel;
  assign ifa.req_we       = req_we;
  assign ifb.req_we       = req_we;
  assign ifa.req_size     = req_size;
  assign ifb.req_size     = req_size;
  assign ifa.req_unsigned = req_unsigned;
  assign ifb.req_unsigned = req_unsigned;
  assign ifa.addr         = addr;
  assign ifb.addr         = addr;
  assign ifa.wdata        = wdata;
  assign ifb.wdata        = wdata;

  logic        ready_m, resp_m, fault_m;
  logic [31:0] rdata_m;
  state_t      state_m;
  assign ready_m = sel ? ifb.ready      : ifa.ready;
  assign resp_m  = sel ? ifb.resp_valid : ifa.resp_valid;
  assign fault_m = sel ? ifb.fault      : ifa.fault;
  assign rdata_m = sel ? ifb.rdata      : ifa.rdata;
  assign state_m = sel ? state_b        : state_a;

  data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave), .state(state_a));
  data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave), .state(state_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request and waits for its response; returns response data and timing.
  task automatic access(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic flt,
                        output int lat, output int rdy_low);
    int w;
    logic got;
    w = 0; got = 1'b0; rd = '0; flt = 1'b0; lat = 0; rdy_low = 0;
    @(negedge clk);
    while (!ready_m && w < 50) begin
      @(negedge clk);
      w++;
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    addr = a; wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (resp_m) begin
        rd = rdata_m; flt = fault_m; lat = k - 1; got = 1'b1;
        break;
      end
      if (!ready_m) rdy_low++;
      @(negedge clk);
    end
    chk({tag, "_resp_seen"}, 32'(got), 32'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(resp_m), 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic flt; int lat, rl;
    access(tag, 1'b0, sz, uns, a, 32'h0, rd, flt, lat, rl);
    chk({tag, "_rdata"}, rd, exp);
    chk({tag, "_fault"}, 32'(flt), 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd; logic flt; int lat, rl;
    access(tag, 1'b1, sz, 1'b0, a, wd, rd, flt, lat, rl);
    chk({tag, "_rdata"}, rd, 32'h0);
    chk({tag, "_fault"}, 32'(flt), 32'd0);
  endtask

  task automatic do_fault(input string tag, input logic we, input logic [1:0] sz,
                          input logic [31:0] a);
    logic [31:0] rd; logic flt; int lat, rl;
    access(tag, we, sz, 1'b0, a, 32'hCAFE_F00D, rd, flt, lat, rl);
    chk({tag, "_fault"}, 32'(flt), 32'd1);
    chk({tag, "_rdata"}, rd, 32'h0);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
  endtask

  initial begin
    logic [31:0] rd;
    logic flt;
    int lat, rl, seen;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_ready", 32'(ready_m), 32'd1);
      chk("rst_resp", 32'(resp_m), 32'd0);
      chk("rst_rdata", rdata_m, 32'h0);
      chk("rst_fault", 32'(fault_m), 32'd0);
      chk("rst_state", 32'(state_m), 32'(ST_IDLE));
    end
    sel = 1'b0;
    reset = 1'b0;

    // Word store then load, with response timing
    do_store("sw10", SZ_WORD, 32'h10, 32'hDEAD_BEEF);
    access("lw10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, flt, lat, rl);
    chk("lw10_rdata", rd, 32'hDEAD_BEEF);
    chk("lw10_lat", 32'(lat), 32'd3);
    chk("lw10_ready_low", 32'(rl), 32'd3);

    // Sub-word loads with extension
    do_load("lb13", SZ_BYTE, 1'b0, 32'h13, 32'hFFFF_FFDE);
    do_load("lbu13", SZ_BYTE, 1'b1, 32'h13, 32'h0000_00DE);
    do_load("lh12", SZ_HALF, 1'b0, 32'h12, 32'hFFFF_DEAD);
    do_load("lhu10", SZ_HALF, 1'b1, 32'h10, 32'h0000_BEEF);
    do_load("lw_uns", SZ_WORD, 1'b1, 32'h10, 32'hDEAD_BEEF);

    // Partial stores only touch their lanes
    do_store("sb11", SZ_BYTE, 32'h11, 32'h0000_0055);
    do_load("lw_after_sb", SZ_WORD, 1'b0, 32'h10, 32'hDEAD_55EF);
    do_store("sh12", SZ_HALF, 32'h12, 32'h0000_1234);
    do_load("lw_after_sh", SZ_WORD, 1'b0, 32'h10, 32'h1234_55EF);

    // Misaligned and reserved-size requests
    do_fault("f_lw12", 1'b0, SZ_WORD, 32'h12);
    do_fault("f_sh11", 1'b1, SZ_HALF, 32'h11);
    do_fault("f_rsvd", 1'b1, SZ_RSVD, 32'h10);
    do_load("lw_after_faults", SZ_WORD, 1'b0, 32'h10, 32'h1234_55EF);

    // Aliasing: high address bits ignored
    do_load("lw_alias", SZ_WORD, 1'b0, 32'h0001_0410, 32'h1234_55EF);

    // Reset in WAIT aborts the store
    do_store("sw20_zero", SZ_WORD, 32'h20, 32'h0);
    do_store("sw30_zero", SZ_WORD, 32'h30, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; addr = 32'h20; wdata = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_in_wait", 32'(state_m), 32'(ST_WAIT));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_idle", 32'(state_m), 32'(ST_IDLE));
    chk("abort_ready", 32'(ready_m), 32'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_m) seen++;
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    do_load("lw20_after_abort", SZ_WORD, 1'b0, 32'h20, 32'h0);

    // A request pulsed while busy is dropped
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; addr = 32'h40; wdata = 32'h1111_1111;
    @(negedge clk);
    req_valid = 1'b1; addr = 32'h30; wdata = 32'hAAAA_AAAA;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_m) seen++;
    end
    chk("busy_one_resp", 32'(seen), 32'd1);
    do_load("lw30_untouched", SZ_WORD, 1'b0, 32'h30, 32'h0);
    do_load("lw40_written", SZ_WORD, 1'b0, 32'h40, 32'h1111_1111);

    // Zero-latency instance
    sel = 1'b1;
    do_store("z_sw10", SZ_WORD, 32'h10, 32'hDEAD_BEEF);
    access("z_lw10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, flt, lat, rl);
    chk("z_lw10_rdata", rd, 32'hDEAD_BEEF);
    chk("z_lw10_lat", 32'(lat), 32'd1);
    chk("z_lw10_ready_low", 32'(rl), 32'd1);
    do_load("z_lb13", SZ_BYTE, 1'b0, 32'h13, 32'hFFFF_FFDE);
    do_load("z_lbu13", SZ_BYTE, 1'b1, 32'h13, 32'h0000_00DE);
    do_load("z_lh12", SZ_HALF, 1'b0, 32'h12, 32'hFFFF_DEAD);
    do_load("z_lhu10", SZ_HALF, 1'b1, 32'h10, 32'h0000_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
